// File: rtl/io_timer_nch_pkg.sv
// Shared register-map constants and helpers for the multi-channel io timer.
package io_timer_pkg;

   typedef enum logic [1:0] {
      REG_CTRL     = 2'd0,
      REG_PRESCALE = 2'd1,
      REG_COMPARE  = 2'd2,
      REG_COUNT    = 2'd3
   } reg_sel_e;

   localparam int unsigned REGS_PER_CH = 4;

   localparam int unsigned CTRL_EN       = 0;
   localparam int unsigned CTRL_PERIODIC = 1;
   localparam int unsigned CTRL_IRQ_EN   = 2;

   // Largest window: 8 channels of 4 words plus STATUS.
   localparam int unsigned WIN_WORDS_MAX = 8 * REGS_PER_CH + 1;

   function automatic int unsigned status_off(input int unsigned n_ch);
      return REGS_PER_CH * n_ch;
   endfunction

   function automatic int unsigned win_words(input int unsigned n_ch);
      return REGS_PER_CH * n_ch + 1;
   endfunction

endpackage

// File: rtl/io_timer_nch_if.sv
// io-bus write/read port bundle including the read-data daisy chain.
interface io_timer_nch_if;
   logic        dma_io_we;
   logic [15:2] dma_io_wadr;
   logic [31:0] dma_io_wdata;
   logic [15:2] dma_io_radr;
   logic        dma_io_radr_en;
   logic [31:0] dma_io_rdata_in;
   logic [31:0] dma_io_rdata;

   modport master (
      output dma_io_we, dma_io_wadr, dma_io_wdata,
      output dma_io_radr, dma_io_radr_en, dma_io_rdata_in,
      input  dma_io_rdata
   );

   modport slave (
      input  dma_io_we, dma_io_wadr, dma_io_wdata,
      input  dma_io_radr, dma_io_radr_en, dma_io_rdata_in,
      output dma_io_rdata
   );
endinterface

// File: rtl/io_timer_nch_chan.sv
// One timer channel: CTRL/PRESCALE/COMPARE/COUNT registers, prescaler,
// counter and a single-cycle compare-match pulse.
module io_timer_chan
   import io_timer_pkg::*;
#(
   parameter int unsigned CNT_W = 32,
   parameter int unsigned PRE_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_wr,
   input  reg_sel_e         i_sel,
   input  logic [31:0]      i_wdata,
   output logic             o_en,
   output logic             o_periodic,
   output logic             o_irq_en,
   output logic [PRE_W-1:0] o_prescale,
   output logic [CNT_W-1:0] o_compare,
   output logic [CNT_W-1:0] o_count,
   output logic             o_match
);

   logic             r_en, r_periodic, r_irq_en;
   logic [PRE_W-1:0] r_prescale, r_pre_cnt;
   logic [CNT_W-1:0] r_compare, r_count;

   logic             w_tick, w_match, w_en_nxt;
   logic [PRE_W-1:0] w_pre_nxt;
   logic [CNT_W-1:0] w_count_nxt;

   assign w_tick  = r_en && (r_pre_cnt == r_prescale);
   assign w_match = w_tick && (r_count == r_compare);

   // Bus writes are applied last so they override tick effects.
   always_comb begin
      w_en_nxt = r_en;
      if (w_match && !r_periodic) w_en_nxt = 1'b0;
      if (i_wr && i_sel == REG_CTRL) w_en_nxt = i_wdata[CTRL_EN];

      w_count_nxt = r_count;
      if (w_tick) w_count_nxt = w_match ? (r_periodic ? '0 : r_count) : r_count + CNT_W'(1);
      if (i_wr && i_sel == REG_COUNT) w_count_nxt = i_wdata[CNT_W-1:0];

      w_pre_nxt = '0;
      if (r_en && w_en_nxt && !w_tick) w_pre_nxt = r_pre_cnt + PRE_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_en       <= 1'b0;
         r_periodic <= 1'b0;
         r_irq_en   <= 1'b0;
         r_prescale <= '0;
         r_pre_cnt  <= '0;
         r_compare  <= '0;
         r_count    <= '0;
      end else begin
         r_en      <= w_en_nxt;
         r_pre_cnt <= w_pre_nxt;
         r_count   <= w_count_nxt;
         if (i_wr) begin
            case (i_sel)
               REG_CTRL: begin
                  r_periodic <= i_wdata[CTRL_PERIODIC];
                  r_irq_en   <= i_wdata[CTRL_IRQ_EN];
               end
               REG_PRESCALE: r_prescale <= i_wdata[PRE_W-1:0];
               REG_COMPARE:  r_compare  <= i_wdata[CNT_W-1:0];
               default: ;
            endcase
         end
      end
   end

   assign o_en       = r_en;
   assign o_periodic = r_periodic;
   assign o_irq_en   = r_irq_en;
   assign o_prescale = r_prescale;
   assign o_compare  = r_compare;
   assign o_count    = r_count;
   assign o_match    = w_match;

endmodule

// File: rtl/io_timer_nch.sv
// N-channel compare timer on the io-bus: address decode, W1C STATUS,
// registered read mux and read-data chain pass-through.
module io_timer_nch
   import io_timer_pkg::*;
#(
   parameter int unsigned N_CH     = 4,
   parameter int unsigned CNT_W    = 32,
   parameter int unsigned PRE_W    = 16,
   parameter logic [15:0] BASE_ADR = 16'hC400
) (
   input  logic             clk,
   input  logic             rst_n,
   io_timer_nch_if.slave    bus,
   output logic [N_CH-1:0]  irq,
   output logic             irq_any
);

   localparam logic [13:0]  BASE_W     = BASE_ADR[15:2];
   localparam int unsigned  WIN        = win_words(N_CH);
   localparam int unsigned  STATUS_OFF = status_off(N_CH);

   logic [13:0]     w_woff, w_roff;
   logic            w_wr_hit, w_rd_hit, w_wr_status;
   logic [N_CH-1:0] w_wr_ch, w_w1c, w_match;
   reg_sel_e        w_wr_sel;

   logic            w_en [N_CH];
   logic            w_periodic [N_CH];
   logic [N_CH-1:0] w_irq_en;
   logic [PRE_W-1:0] w_prescale [N_CH];
   logic [CNT_W-1:0] w_compare [N_CH];
   logic [CNT_W-1:0] w_count [N_CH];

   logic [N_CH-1:0] r_pending;
   logic            r_hit_q;
   logic [31:0]     r_rdata_q;
   logic [31:0]     w_rsel;

   // Offsets below the base wrap to large values and fall outside the window.
   assign w_woff      = bus.dma_io_wadr - BASE_W;
   assign w_roff      = bus.dma_io_radr - BASE_W;
   assign w_wr_hit    = bus.dma_io_we && (w_woff < 14'(WIN));
   assign w_rd_hit    = w_roff < 14'(WIN);
   assign w_wr_status = w_wr_hit && (w_woff == 14'(STATUS_OFF));
   assign w_wr_sel    = reg_sel_e'(w_woff[1:0]);
   assign w_w1c       = w_wr_status ? bus.dma_io_wdata[N_CH-1:0] : '0;

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      assign w_wr_ch[g] = w_wr_hit && (w_woff[13:2] == 12'(g));

      io_timer_chan #(
         .CNT_W (CNT_W),
         .PRE_W (PRE_W)
      ) u_chan (
         .clk        (clk),
         .rst_n      (rst_n),
         .i_wr       (w_wr_ch[g]),
         .i_sel      (w_wr_sel),
         .i_wdata    (bus.dma_io_wdata),
         .o_en       (w_en[g]),
         .o_periodic (w_periodic[g]),
         .o_irq_en   (w_irq_en[g]),
         .o_prescale (w_prescale[g]),
         .o_compare  (w_compare[g]),
         .o_count    (w_count[g]),
         .o_match    (w_match[g])
      );
   end

   always_comb begin
      w_rsel = '0;
      if (w_roff == 14'(STATUS_OFF)) begin
         w_rsel[N_CH-1:0] = r_pending;
      end else begin
         for (int unsigned c = 0; c < N_CH; c++) begin
            if (w_roff[13:2] == 12'(c)) begin
               case (reg_sel_e'(w_roff[1:0]))
                  REG_CTRL: begin
                     w_rsel[CTRL_EN]       = w_en[c];
                     w_rsel[CTRL_PERIODIC] = w_periodic[c];
                     w_rsel[CTRL_IRQ_EN]   = w_irq_en[c];
                  end
                  REG_PRESCALE: w_rsel[PRE_W-1:0] = w_prescale[c];
                  REG_COMPARE:  w_rsel[CNT_W-1:0] = w_compare[c];
                  default:      w_rsel[CNT_W-1:0] = w_count[c];
               endcase
            end
         end
      end
   end

   // A new match outranks a same-cycle W1C of that bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pending <= '0;
         r_hit_q   <= 1'b0;
         r_rdata_q <= '0;
      end else begin
         r_pending <= (r_pending & ~w_w1c) | w_match;
         if (bus.dma_io_radr_en) begin
            r_hit_q   <= w_rd_hit;
            r_rdata_q <= w_rsel;
         end
      end
   end

   assign bus.dma_io_rdata = r_hit_q ? r_rdata_q : bus.dma_io_rdata_in;
   assign irq              = r_pending & w_irq_en;
   assign irq_any          = |irq;

endmodule

// File: tb/tb_io_timer_nch.sv
// Bench for io_timer_nch: directed register-map scenarios plus random bus
// traffic, all checked every cycle against a behavioural register model.
module tb_io_timer_nch;
   localparam int N      = 4;
   localparam int BASE_W = 'h3100;
   localparam int STAT_B = 'hC400 + 16 * N;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [N-1:0] irq;
   logic         irq_any;

   io_timer_nch_if u_if ();

   io_timer_nch #(
      .N_CH     (N),
      .CNT_W    (32),
      .PRE_W    (16),
      .BASE_ADR (16'hC400)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .bus     (u_if),
      .irq     (irq),
      .irq_any (irq_any)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic        m_en [N];
   logic        m_per [N];
   logic        m_ie [N];
   logic [15:0] m_ps [N];
   logic [15:0] m_pre [N];
   logic [31:0] m_cmp [N];
   logic [31:0] m_cnt [N];
   logic [N-1:0] m_pend;
   logic        m_hit;
   logic [31:0] m_rd;

   function automatic logic [31:0] model_reg(input logic [13:0] a);
      int w;
      int c;
      w = int'(a) - BASE_W;
      if (w < 0 || w > 4 * N) return 32'h0;
      if (w == 4 * N) return 32'(m_pend);
      c = w / 4;
      case (w % 4)
         0:       return {29'h0, m_ie[c], m_per[c], m_en[c]};
         1:       return 32'(m_ps[c]);
         2:       return m_cmp[c];
         default: return m_cnt[c];
      endcase
   endfunction

   function automatic logic [N-1:0] model_irq();
      logic [N-1:0] v;
      for (int c = 0; c < N; c++) v[c] = m_pend[c] & m_ie[c];
      return v;
   endfunction

   always @(posedge clk or negedge rst_n) begin : model
      int           ww;
      logic         wv;
      logic [N-1:0] set_v, clr_v;
      logic [31:0]  wd;
      if (!rst_n) begin
         for (int c = 0; c < N; c++) begin
            m_en[c] <= 1'b0; m_per[c] <= 1'b0; m_ie[c] <= 1'b0;
            m_ps[c] <= '0; m_pre[c] <= '0; m_cmp[c] <= '0; m_cnt[c] <= '0;
         end
         m_pend <= '0;
         m_hit  <= 1'b0;
         m_rd   <= '0;
      end else begin
         wd = u_if.dma_io_wdata;
         ww = int'(u_if.dma_io_wadr) - BASE_W;
         wv = u_if.dma_io_we && ww >= 0 && ww <= 4 * N;
         if (u_if.dma_io_radr_en) begin
            m_hit <= (int'(u_if.dma_io_radr) - BASE_W >= 0) && (int'(u_if.dma_io_radr) - BASE_W <= 4 * N);
            m_rd  <= model_reg(u_if.dma_io_radr);
         end
         set_v = '0;
         clr_v = (wv && ww == 4 * N) ? wd[N-1:0] : '0;
         for (int c = 0; c < N; c++) begin
            logic        tick, match, en_n;
            logic [31:0] cnt_n;
            tick  = m_en[c] && (m_pre[c] == m_ps[c]);
            match = tick && (m_cnt[c] == m_cmp[c]);
            if (match) set_v[c] = 1'b1;
            cnt_n = m_cnt[c];
            if (tick) cnt_n = match ? (m_per[c] ? 32'h0 : m_cnt[c]) : m_cnt[c] + 32'h1;
            en_n = (match && !m_per[c]) ? 1'b0 : m_en[c];
            if (wv && ww == 4 * c) begin
               en_n = wd[0];
               m_per[c] <= wd[1];
               m_ie[c]  <= wd[2];
            end
            if (wv && ww == 4 * c + 1) m_ps[c] <= wd[15:0];
            if (wv && ww == 4 * c + 2) m_cmp[c] <= wd;
            if (wv && ww == 4 * c + 3) cnt_n = wd;
            m_pre[c] <= (m_en[c] && en_n) ? (tick ? 16'h0 : m_pre[c] + 16'h1) : 16'h0;
            m_en[c]  <= en_n;
            m_cnt[c] <= cnt_n;
         end
         m_pend <= (m_pend & ~clr_v) | set_v;
      end
   end

   // ---------------- per-cycle compare ----------------
   always begin
      @(negedge clk);
      #1;
      chk("irq", 32'(irq), 32'(model_irq()));
      chk("irq_any", 32'(irq_any), 32'(|model_irq()));
      chk("rdata", u_if.dma_io_rdata, m_hit ? m_rd : u_if.dma_io_rdata_in);
   end

   // ---------------- stimulus ----------------
   task automatic wr(input int badr, input logic [31:0] d);
      u_if.dma_io_we    = 1'b1;
      u_if.dma_io_wadr  = 14'(badr >> 2);
      u_if.dma_io_wdata = d;
      @(negedge clk);
      u_if.dma_io_we    = 1'b0;
   endtask

   task automatic rd_chk(input string nm, input int badr, input logic [31:0] exp);
      u_if.dma_io_radr_en = 1'b1;
      u_if.dma_io_radr    = 14'(badr >> 2);
      @(negedge clk);
      u_if.dma_io_radr_en = 1'b0;
      #1;
      chk(nm, u_if.dma_io_rdata, exp);
   endtask

   task automatic irq_chk(input string nm, input int nwait, input int bitn, input logic exp);
      repeat (nwait) @(negedge clk);
      #1;
      chk(nm, 32'(irq[bitn]), 32'(exp));
   endtask

   initial begin
      rst_n                = 1'b0;
      u_if.dma_io_we       = 1'b0;
      u_if.dma_io_wadr     = '0;
      u_if.dma_io_wdata    = '0;
      u_if.dma_io_radr     = '0;
      u_if.dma_io_radr_en  = 1'b0;
      u_if.dma_io_rdata_in = 32'hDEADBEEF;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      rd_chk("reset_ctrl0", 'hC400, 32'h0);
      rd_chk("outside_window", 'h0100, 32'hDEADBEEF);

      // ch0 periodic, compare 5, tick every clock
      wr('hC404, 0); wr('hC408, 5); wr('hC400, 7);
      irq_chk("ch0_before_match", 5, 0, 1'b0);
      irq_chk("ch0_match", 1, 0, 1'b1);
      chk("ch0_irq_any", 32'(irq_any), 32'h1);
      rd_chk("ch0_count_after_match", 'hC40C, 32'h0);
      wr(STAT_B, 1);
      #1 chk("ch0_w1c", 32'(irq[0]), 32'h0);
      irq_chk("ch0_rearm_before", 3, 0, 1'b0);
      irq_chk("ch0_rearm", 1, 0, 1'b1);
      wr('hC400, 0); wr(STAT_B, 'hF);

      // ch1 one-shot, prescale 3, compare 2
      wr('hC414, 3); wr('hC418, 2); wr('hC410, 5);
      irq_chk("ch1_before_match", 11, 1, 1'b0);
      irq_chk("ch1_match", 1, 1, 1'b1);
      rd_chk("ch1_ctrl_en_cleared", 'hC410, 32'h4);
      rd_chk("ch1_count_frozen", 'hC41C, 32'h2);
      repeat (20) @(negedge clk);
      rd_chk("ch1_count_still", 'hC41C, 32'h2);
      wr(STAT_B, 'hF);

      // ch2 wrap through all-ones
      wr('hC42C, 32'hFFFFFFFE); wr('hC428, 1); wr('hC420, 5);
      rd_chk("ch2_cnt_fe", 'hC42C, 32'hFFFFFFFE);
      rd_chk("ch2_cnt_ff", 'hC42C, 32'hFFFFFFFF);
      rd_chk("ch2_cnt_0", 'hC42C, 32'h0);
      chk("ch2_no_pend_at_wrap", 32'(irq[2]), 32'h0);
      rd_chk("ch2_cnt_1", 'hC42C, 32'h1);
      chk("ch2_pend", 32'(irq[2]), 32'h1);
      rd_chk("ch2_status", STAT_B, 32'h4);
      wr(STAT_B, 'hF); wr('hC420, 0);

      // COUNT write coincident with a tick
      wr('hC434, 0); wr('hC438, 1000); wr('hC430, 3);
      repeat (3) @(negedge clk);
      wr('hC43C, 10);
      rd_chk("ch3_count_write_wins", 'hC43C, 32'd10);
      wr('hC430, 0);

      // W1C coincident with a match
      wr(STAT_B, 'hF);
      wr('hC40C, 0); wr('hC404, 0); wr('hC408, 3); wr('hC400, 3);
      repeat (7) @(negedge clk);
      wr(STAT_B, 1);
      rd_chk("w1c_vs_match", STAT_B, 32'h1);

      // async reset with a read in flight
      wr('hC400, 7);
      #1 chk("pre_reset_irq", 32'(irq), 32'h1);
      u_if.dma_io_radr_en = 1'b1;
      u_if.dma_io_radr    = 14'('hC40C >> 2);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      u_if.dma_io_radr_en = 1'b0;
      #1;
      chk("reset_irq", 32'(irq), 32'h0);
      chk("reset_irq_any", 32'(irq_any), 32'h0);
      chk("reset_rdata", u_if.dma_io_rdata, 32'hDEADBEEF);
      @(negedge clk);
      rst_n = 1'b1;
      for (int w = 0; w <= 4 * N; w++) rd_chk("post_reset_reg", 'hC400 + 4 * w, 32'h0);

      // random traffic against the model
      repeat (3000) begin
         int          word;
         logic [31:0] d;
         @(negedge clk);
         u_if.dma_io_rdata_in = $urandom;
         word = $urandom_range(0, 4 * N);
         case (word % 4)
            0:       d = 32'($urandom_range(0, 7));
            1:       d = 32'($urandom_range(0, 3));
            2:       d = 32'($urandom_range(0, 9));
            default: d = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFF0 + 32'($urandom_range(0, 15))
                                                    : 32'($urandom_range(0, 9));
         endcase
         if (word == 4 * N) d = $urandom;
         u_if.dma_io_we     = ($urandom_range(0, 3) == 0);
         u_if.dma_io_wadr   = 14'(BASE_W + word);
         u_if.dma_io_wdata  = d;
         u_if.dma_io_radr_en = ($urandom_range(0, 2) == 0);
         u_if.dma_io_radr   = ($urandom_range(0, 3) == 0) ? 14'($urandom)
                                                         : 14'(BASE_W + $urandom_range(0, 4 * N));
      end
      @(negedge clk);
      u_if.dma_io_we      = 1'b0;
      u_if.dma_io_radr_en = 1'b0;
      repeat (2) @(negedge clk);
      #2;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
